// File: rtl/gsim_residual_check.sv
// gsim_residual_check: residual r = b - A*x check of the 16x16 banded Gauss-Seidel system, reports max |r| and pass/fail
module gsim_residual_check (
  input  logic        clk,
  input  logic        reset,
  input  logic        b_en,
  input  logic [15:0] b_in,
  input  logic        x_valid,
  input  logic [31:0] x_in,
  output logic        chk_valid,
  output logic        chk_pass,
  output logic [31:0] max_res,
  output logic [4:0]  fail_cnt
);
  localparam logic [39:0] TOL = 40'h00_0000_0100;
  typedef enum logic [1:0] {COLLECT, EVAL, DONE} state_t;
  state_t state_q;
  logic signed [15:0] b_q [16];
  logic signed [31:0] x_q [16];
  logic [4:0] b_cnt_q, x_cnt_q, fail_q, b_cnt_d, x_cnt_d, fail_d;
  logic [3:0] row_q;
  logic issued_q, a_vld_q, a_last_q, b_take, x_take;
  logic [39:0] a_q, max_q, a_d, max_d;
  logic signed [39:0] s0, s1, s2, s3, s_d, r_d;
  int ri;
  function automatic logic signed [39:0] xe(input int k);
    return (k < 0 || k > 15) ? 40'sd0 : {{8{x_q[k[3:0]][31]}}, x_q[k[3:0]]};
  endfunction
  assign b_take = state_q == COLLECT && b_en && !b_cnt_q[4];
  assign x_take = state_q == COLLECT && x_valid && !x_cnt_q[4];
  assign b_cnt_d = b_cnt_q + 5'(b_take);
  assign x_cnt_d = x_cnt_q + 5'(x_take);
  assign ri = int'(row_q);
  always_comb begin
    s0 = xe(ri);
    s1 = xe(ri - 1) + xe(ri + 1);
    s2 = xe(ri - 2) + xe(ri + 2);
    s3 = xe(ri - 3) + xe(ri + 3);
    s_d = (s0 <<< 4) + (s0 <<< 2) - ((s1 <<< 3) + (s1 <<< 2) + s1) + (s2 <<< 2) + (s2 <<< 1) - s3;
    r_d = {{8{b_q[row_q][15]}}, b_q[row_q], 16'h0} - s_d;
    a_d = r_d[39] ? -r_d : r_d;
    max_d = a_q > max_q ? a_q : max_q;
    fail_d = fail_q + 5'(a_q > TOL);
  end
  always_ff @(posedge clk) begin
    if (b_take) b_q[b_cnt_q[3:0]] <= b_in;
    if (x_take) x_q[x_cnt_q[3:0]] <= x_in;
  end
  // Row residual is registered, then folded into max/count a cycle later,
  // so DONE lands 17 edges after the last captured word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= COLLECT;
      b_cnt_q   <= '0;
      x_cnt_q   <= '0;
      row_q     <= '0;
      issued_q  <= 1'b0;
      a_vld_q   <= 1'b0;
      a_last_q  <= 1'b0;
      a_q       <= '0;
      max_q     <= '0;
      fail_q    <= '0;
      chk_valid <= 1'b0;
      chk_pass  <= 1'b0;
      max_res   <= '0;
      fail_cnt  <= '0;
    end else if (state_q == COLLECT) begin
      b_cnt_q <= b_cnt_d;
      x_cnt_q <= x_cnt_d;
      if (b_cnt_d[4] && x_cnt_d[4]) state_q <= EVAL;
    end else if (state_q == EVAL) begin
      if (!issued_q) begin
        a_q      <= a_d;
        a_vld_q  <= 1'b1;
        a_last_q <= &row_q;
        issued_q <= &row_q;
        if (!(&row_q)) row_q <= row_q + 4'd1;
      end
      if (a_vld_q) begin
        max_q  <= max_d;
        fail_q <= fail_d;
        if (a_last_q) begin
          state_q   <= DONE;
          chk_valid <= 1'b1;
          chk_pass  <= fail_d == 5'd0;
          max_res   <= |max_d[39:32] ? 32'hFFFF_FFFF : max_d[31:0];
          fail_cnt  <= fail_d;
        end
      end
    end
  end
endmodule

// File: tb/tb_gsim_residual_check.sv
// tb_gsim_residual_check: randomized and directed self-check of gsim_residual_check against a plain-arithmetic model
module tb_gsim_residual_check;
  logic clk = 0, reset = 1, b_en = 0, x_valid = 0, chk_valid, chk_pass;
  logic [15:0] b_in = 0;
  logic [31:0] x_in = 0, max_res;
  logic [4:0] fail_cnt;
  int checks = 0, errors = 0, cyc = 0, last_edge = -1;
  bit started = 0;
  int tb_b [16];
  int tb_x [16];
  logic [31:0] exp_max;
  int exp_fail;
  bit exp_pass;

  gsim_residual_check dut (
    .clk(clk), .reset(reset), .b_en(b_en), .b_in(b_in), .x_valid(x_valid),
    .x_in(x_in), .chk_valid(chk_valid), .chk_pass(chk_pass), .max_res(max_res),
    .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic void model();
    int coef [4] = '{20, -13, 6, -1};
    longint m = 0, s, r, a;
    int f = 0;
    for (int i = 0; i < 16; i++) begin
      s = 0;
      for (int d = -3; d <= 3; d++)
        if (i + d >= 0 && i + d < 16)
          s += longint'(coef[d < 0 ? -d : d]) * longint'(tb_x[i + d]);
      r = longint'(tb_b[i]) * 65536 - s;
      a = r < 0 ? -r : r;
      if (a > m) m = a;
      if (a > 256) f++;
    end
    exp_max = m > 64'hFFFF_FFFF ? 32'hFFFF_FFFF : 32'(m);
    exp_fail = f;
    exp_pass = f == 0;
  endfunction

  always @(negedge clk) begin
    if (!reset && started) begin
      bit ev;
      ev = last_edge >= 0 && cyc >= last_edge + 17;
      checks++;
      if (chk_valid !== ev || chk_pass !== (ev & exp_pass) || max_res !== (ev ? exp_max : 32'h0) ||
          fail_cnt !== (ev ? 5'(exp_fail) : 5'd0)) begin
        errors++;
        $display("FAIL cmp cyc=%0d got v=%b p=%b max=%h f=%0d exp v=%b p=%b max=%h f=%0d",
                 cyc, chk_valid, chk_pass, max_res, fail_cnt, ev, ev & exp_pass,
                 ev ? exp_max : 32'h0, ev ? exp_fail : 0);
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #2 reset = 1;
    last_edge = -1;
    #1 checks++;
    if (chk_valid !== 0 || chk_pass !== 0 || max_res !== 0 || fail_cnt !== 0) begin
      errors++;
      $display("FAIL reset_async got v=%b p=%b max=%h f=%0d exp all 0", chk_valid, chk_pass, max_res, fail_cnt);
    end
    b_en = 0;
    x_valid = 0;
    repeat (2) @(negedge clk);
    reset = 0;
  endtask

  task automatic run(input int mode, input bit abort, input bit lit, input logic [31:0] lmax, input int lfail);
    int bc = 0, xc = 0;
    model();
    if (lit) begin
      checks += 2;
      if (exp_max !== lmax) begin errors++; $display("FAIL model_max got %h exp %h", exp_max, lmax); end
      if (exp_fail != lfail) begin errors++; $display("FAIL model_fail got %0d exp %0d", exp_fail, lfail); end
    end
    if (mode == 0) begin
      for (int i = 0; i < 16; i++) begin
        @(negedge clk); b_en = 1; b_in = 16'(tb_b[i]); x_valid = 0;
      end
      for (int k = 0; k < 40; k++) begin
        @(negedge clk); b_en = 1; b_in = 16'($urandom); x_valid = 1; x_in = k < 16 ? tb_x[k] : 32'h0;
        if (k == 15) last_edge = cyc + 1;
      end
    end else if (mode == 1) begin
      for (int k = 0; k < 24; k++) begin
        @(negedge clk); b_en = k < 16; b_in = k < 16 ? 16'(tb_b[k]) : 16'($urandom);
        x_valid = 1; x_in = k < 16 ? tb_x[k] : 32'h0;
        if (k == 15) last_edge = cyc + 1;
      end
    end else begin
      while (bc < 16 || xc < 16) begin
        @(negedge clk);
        b_en = 1'($urandom); x_valid = 1'($urandom);
        b_in = bc < 16 ? 16'(tb_b[bc]) : 16'($urandom);
        x_in = xc < 16 ? tb_x[xc] : $urandom;
        if (b_en && bc < 16) bc++;
        if (x_valid && xc < 16) xc++;
        if (bc == 16 && xc == 16) last_edge = cyc + 1;
      end
    end
    if (abort) begin
      while (cyc < last_edge + 8) @(negedge clk);
      do_reset();
      return;
    end
    for (int k = 0; k < 40 && !chk_valid; k++) begin
      @(negedge clk); b_en = 1'($urandom); x_valid = 1'($urandom); b_in = 16'($urandom); x_in = $urandom;
    end
    checks++;
    if (!chk_valid) begin errors++; $display("FAIL timeout got chk_valid=0 exp 1"); end
    repeat (5) begin
      @(negedge clk); b_en = 1'($urandom); x_valid = 1'($urandom); b_in = 16'($urandom); x_in = $urandom;
    end
    if (lit) begin
      checks += 2;
      if (max_res !== lmax) begin errors++; $display("FAIL lit_max got %h exp %h", max_res, lmax); end
      if (fail_cnt !== 5'(lfail)) begin errors++; $display("FAIL lit_fail got %0d exp %0d", fail_cnt, lfail); end
    end
    do_reset();
  endtask

  task automatic fill_x(input int v);
    for (int i = 0; i < 16; i++) tb_x[i] = v;
  endtask

  initial begin
    int bpat [16] = '{12, -1, 5, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 5, -1, 12};
    exp_max = 0; exp_fail = 0; exp_pass = 1;
    repeat (2) @(negedge clk);
    reset = 0;
    started = 1;
    checks++;
    if (chk_valid !== 0 || max_res !== 0 || fail_cnt !== 0 || chk_pass !== 0) begin
      errors++; $display("FAIL reset_state got v=%b max=%h f=%0d exp 0", chk_valid, max_res, fail_cnt);
    end
    for (int i = 0; i < 16; i++) tb_b[i] = 0;
    fill_x(0);
    run(0, 0, 1, 32'h0, 0);
    tb_b = bpat; fill_x(32'h0001_0000);
    run(0, 0, 1, 32'h0, 0);
    run(1, 0, 1, 32'h0, 0);
    for (int i = 0; i < 16; i++) tb_b[i] = 4;
    run(0, 0, 1, 32'h0008_0000, 6);
    run(1, 0, 1, 32'h0008_0000, 6);
    run(2, 0, 1, 32'h0008_0000, 6);
    for (int i = 0; i < 16; i++) tb_b[i] = -32768;
    fill_x(32'h7FFF_FFFF);
    run(1, 0, 1, 32'hFFFF_FFFF, 14);
    run(2, 1, 0, 0, 0);
    tb_b = bpat; fill_x(32'h0001_0000);
    run(2, 0, 1, 32'h0, 0);
    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < 16; i++) begin
        tb_b[i] = int'($urandom_range(0, 40)) - 20;
        tb_x[i] = t < 4 ? int'($urandom) : tb_b[i] * 65536 / 4 + int'($urandom_range(0, 2000)) - 1000;
      end
      run(t % 3, t == 5, 0, 0, 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
